// File: rtl/vram_scanout.sv
// vram_scanout: the video-side reader of the dual-port VRAM.
//
// It generates raster timing from the pixel clock. It fetches 1bpp bitmap
// bytes over the VRAM read port and serialises them MSB first into RGB
// pixels. Pixels inside the bitmap window use fg_color or bg_color. The rest
// of the active area uses border_color. It also emits a one-cycle
// vertical-blank pulse for the CPU interrupt logic.
//
// Ports:
//   clk           pixel clock
//   resetn        synchronous active-low reset
//   vram_addr     registered VRAM read address (ADDRESS_WIDTH bits)
//   vram_data     VRAM read data, valid one clock after vram_addr
//   fg_color      RGB888 colour for bitmap bit = 1
//   bg_color      RGB888 colour for bitmap bit = 0
//   border_color  RGB888 colour for the active area outside the bitmap
//   red/green/blue registered pixel colour
//   hsync, vsync  sync outputs, active level set by SYNC_POL
//   de            data enable (active area)
//   vblank_irq    one-clock pulse at the start of vertical blank
//
// Every output for counter position (hc, vc) appears three clocks after the
// counters hold that position:
//   stage 0: the counters; the fetch address is registered here.
//   stage 1: the VRAM registers its read data.
//   stage 2: the pixel is formed into the output registers.
module vram_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int SYNC_POL      = 0,
  parameter int BM_W          = 256,
  parameter int BM_H          = 192,
  parameter int X_OFF         = 192,
  parameter int Y_OFF         = 144,
  parameter int BASE          = 0,
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic [ADDRESS_WIDTH-1:0] vram_addr,
  input  logic [7:0]               vram_data,
  input  logic [23:0]              fg_color,
  input  logic [23:0]              bg_color,
  input  logic [23:0]              border_color,
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic                     vblank_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so that end-of-range constants equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int BYTES_PER_LINE = BM_W / 8;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WIN_X0    = HW'(X_OFF);
  localparam logic [HW-1:0] WIN_X1    = HW'(X_OFF + BM_W);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WIN_Y0    = VW'(Y_OFF);
  localparam logic [VW-1:0] WIN_Y1    = VW'(Y_OFF + BM_H);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  // Raster counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Stage 0: decode the current counter position
  logic                     s0_de, s0_hs, s0_vs, s0_win, s0_fetch, s0_irq;
  logic [ADDRESS_WIDTH-1:0] s0_addr;

  always_comb begin
    s0_de  = (hc < H_ACT_END) && (vc < V_ACT_END);
    s0_hs  = (hc >= HS_BEGIN && hc < HS_END) ? SYNC_ON : ~SYNC_ON;
    s0_vs  = (vc >= VS_BEGIN && vc < VS_END) ? SYNC_ON : ~SYNC_ON;
    s0_win = (hc >= WIN_X0) && (hc < WIN_X1) && (vc >= WIN_Y0) && (vc < WIN_Y1);
    // X_OFF is a multiple of 8, so byte boundaries are where hc[2:0] is zero.
    s0_fetch = s0_win && (hc[2:0] == 3'd0);
    s0_irq   = (hc == '0) && (vc == V_ACT_END);
    // Only meaningful inside the window; the cast wraps modulo 2^ADDRESS_WIDTH.
    s0_addr  = ADDRESS_WIDTH'(BASE + (int'(vc) - Y_OFF) * BYTES_PER_LINE
                              + (int'(hc) - X_OFF) / 8);
  end

  // Stages 1 and 2 carry the pixel attributes alongside the VRAM read.
  logic p1_de, p1_hs, p1_vs, p1_win, p1_load, p1_irq;
  logic p2_de, p2_hs, p2_vs, p2_win, p2_load, p2_irq;
  logic [7:0] shift_byte;

  // Pixel formation. On a load cycle the fresh byte's MSB is used directly.
  // The remaining seven bits are kept in shift_byte for the next pixels.
  logic        pix_bit;
  logic [23:0] pix_rgb;

  always_comb begin
    pix_bit = p2_load ? vram_data[7] : shift_byte[7];
    pix_rgb = 24'h0;
    if (p2_de) begin
      if (p2_win) pix_rgb = pix_bit ? fg_color : bg_color;
      else        pix_rgb = border_color;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vram_addr  <= '0;
      p1_de      <= 1'b0;
      p1_hs      <= ~SYNC_ON;
      p1_vs      <= ~SYNC_ON;
      p1_win     <= 1'b0;
      p1_load    <= 1'b0;
      p1_irq     <= 1'b0;
      p2_de      <= 1'b0;
      p2_hs      <= ~SYNC_ON;
      p2_vs      <= ~SYNC_ON;
      p2_win     <= 1'b0;
      p2_load    <= 1'b0;
      p2_irq     <= 1'b0;
      shift_byte <= 8'h0;
      red        <= 8'h0;
      green      <= 8'h0;
      blue       <= 8'h0;
      hsync      <= ~SYNC_ON;
      vsync      <= ~SYNC_ON;
      de         <= 1'b0;
      vblank_irq <= 1'b0;
    end else begin
      if (s0_fetch) vram_addr <= s0_addr;

      p1_de   <= s0_de;
      p1_hs   <= s0_hs;
      p1_vs   <= s0_vs;
      p1_win  <= s0_win;
      p1_load <= s0_fetch;
      p1_irq  <= s0_irq;

      p2_de   <= p1_de;
      p2_hs   <= p1_hs;
      p2_vs   <= p1_vs;
      p2_win  <= p1_win;
      p2_load <= p1_load;
      p2_irq  <= p1_irq;

      shift_byte <= p2_load ? {vram_data[6:0], 1'b0} : {shift_byte[6:0], 1'b0};

      red        <= pix_rgb[23:16];
      green      <= pix_rgb[15:8];
      blue       <= pix_rgb[7:0];
      hsync      <= p2_hs;
      vsync      <= p2_vs;
      de         <= p2_de;
      vblank_irq <= p2_irq;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Testbench for vram_scanout.
//
// A reduced raster keeps whole frames short:
//   - 100 clocks per line and 40 lines per frame.
//   - A 48x16 bitmap at (16,8).
//   - BASE = 16380, so the first bitmap line's address wraps past 2^14.
// A frame-level model predicts every output from the number of clocks since
// reset release. Literal checks pin specific positions of that model.
module tb_vram_scanout;

  localparam int HA = 80, HFP = 4, HS = 8, HBP = 8;
  localparam int VA = 32, VFP = 2, VS = 2, VBP = 4;
  localparam int HT = HA + HFP + HS + HBP;   // 100
  localparam int VT = VA + VFP + VS + VBP;   // 40
  localparam int BMW = 48, BMH = 16, XO = 16, YO = 8;
  localparam int BASE = 16380, AW = 14;

  localparam logic [23:0] FG_A = 24'hFF8040, BG_A = 24'h102030, BD_A = 24'h00FF00;
  localparam logic [23:0] FG_B = 24'h0000FF, BG_B = 24'hABCDEF, BD_B = 24'h123456;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_data = 8'h0;
  logic [23:0]   fg_color, bg_color, border_color;
  logic [7:0]    red, green, blue;
  logic          hsync, vsync, de, vblank_irq;

  logic [7:0] mem [0:(1<<AW)-1];

  int k = 0;          // clocks since reset release (0 while in reset)
  int tests = 0;
  int fails = 0;
  int irq_count = 0;
  bit running = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0] pat = 8'hA5;

  vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .BM_W(BMW), .BM_H(BMH), .X_OFF(XO), .Y_OFF(YO),
    .BASE(BASE), .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .vram_addr(vram_addr), .vram_data(vram_data),
    .fg_color(fg_color), .bg_color(bg_color), .border_color(border_color),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .vblank_irq(vblank_irq)
  );

  always #5 clk = ~clk;

  // VRAM read port: data valid one clock after the address.
  always @(posedge clk) vram_data <= mem[vram_addr];

  always @(posedge clk) k <= resetn ? k + 1 : 0;

  function automatic bit in_win(int hc, int vc);
    return (hc >= XO) && (hc < XO + BMW) && (vc >= YO) && (vc < YO + BMH);
  endfunction

  function automatic int byte_addr(int hc, int vc);
    return (BASE + (vc - YO) * (BMW / 8) + (hc - XO) / 8) % (1 << AW);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", name, got, expv, k);
    end else begin
      $display("[TB] check %s: 0x%0h ok (k=%0d)", name, got, k);
    end
  endtask

  // Model state used only by the compare process
  int m_n, m_hc, m_vc, m_a;
  logic m_de, m_hs, m_vs, m_irq;
  logic [23:0] m_rgb;
  logic [50:0] got_v, exp_v;

  always @(negedge clk) begin
    if (running) begin
      // vram_addr: last fetch whose counter position precedes the last edge
      if (k == 0) begin
        exp_addr = '0;
      end else begin
        m_n  = k - 1;
        m_hc = m_n % HT;
        m_vc = (m_n / HT) % VT;
        if (in_win(m_hc, m_vc) && ((m_hc - XO) % 8 == 0))
          exp_addr = AW'(byte_addr(m_hc, m_vc));
      end

      // Video outputs: position k-3 of the raster, inactive before that
      m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_irq = 1'b0; m_rgb = 24'h0;
      if (k >= 3) begin
        m_n  = k - 3;
        m_hc = m_n % HT;
        m_vc = (m_n / HT) % VT;
        m_de  = (m_hc < HA) && (m_vc < VA);
        m_hs  = !((m_hc >= HA + HFP) && (m_hc < HA + HFP + HS));
        m_vs  = !((m_vc >= VA + VFP) && (m_vc < VA + VFP + VS));
        m_irq = (m_hc == 0) && (m_vc == VA);
        if (m_de) begin
          if (in_win(m_hc, m_vc)) begin
            m_a = byte_addr(m_hc, m_vc);
            m_rgb = mem[m_a][7 - ((m_hc - XO) % 8)] ? fg_color : bg_color;
          end else begin
            m_rgb = border_color;
          end
        end
      end

      got_v = {de, hsync, vsync, vblank_irq, red, green, blue, vram_addr};
      exp_v = {m_de, m_hs, m_vs, m_irq, m_rgb, exp_addr};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL model k=%0d: got de=%b hs=%b vs=%b irq=%b rgb=%06h addr=%0d, expected de=%b hs=%b vs=%b irq=%b rgb=%06h addr=%0d",
                 k, de, hsync, vsync, vblank_irq, {red, green, blue}, vram_addr,
                 m_de, m_hs, m_vs, m_irq, m_rgb, exp_addr);
      end
      if (vblank_irq === 1'b1) irq_count++;

      // Hand-computed positions (counter index n = vc*100 + hc, seen at k = n+3)
      case (k)
        2:    chk("de_before_fill", {31'b0, de}, 32'd0);
        3:    chk("first_de", {31'b0, de}, 32'd1);
        86:   chk("hsync_before", {31'b0, hsync}, 32'd1);
        87:   chk("hsync_start", {31'b0, hsync}, 32'd0);
        94:   chk("hsync_last", {31'b0, hsync}, 32'd0);
        95:   chk("hsync_end", {31'b0, hsync}, 32'd1);
        817:  chk("first_fetch_addr", 32'(vram_addr), 32'd16380);
        818:  chk("left_border_rgb", {8'h0, red, green, blue}, {8'h0, BD_A});
        849:  chk("wrap_fetch_addr", 32'(vram_addr), 32'd0);
        867:  chk("right_border_rgb", {8'h0, red, green, blue}, {8'h0, BD_A});
        893:  chk("blank_rgb_de", {7'h0, de, red, green, blue}, 32'h0);
        917:  chk("row2_addr", 32'(vram_addr), 32'd2);
        2357: chk("last_line_addr", 32'(vram_addr), 32'd91);
        2800: chk("no_fetch_after_bitmap", 32'(vram_addr), 32'd91);
        3202: chk("irq_before", {31'b0, vblank_irq}, 32'd0);
        3203: chk("irq_pulse", {31'b0, vblank_irq}, 32'd1);
        3204: chk("irq_after", {31'b0, vblank_irq}, 32'd0);
        3402: chk("vsync_before", {31'b0, vsync}, 32'd1);
        3403: chk("vsync_start", {31'b0, vsync}, 32'd0);
        3602: chk("vsync_last", {31'b0, vsync}, 32'd0);
        3603: chk("vsync_end", {31'b0, vsync}, 32'd1);
        default: ;
      endcase
      // First byte 0xA5 serialised MSB first: fg,bg,fg,bg,bg,fg,bg,fg
      if (k >= 819 && k <= 826)
        chk("a5_pixel", {8'h0, red, green, blue}, {8'h0, pat[826 - k] ? FG_A : BG_A});
    end
  end

  task automatic wait_k(input int target);
    while (k < target) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 11);
    mem[16380] = 8'hA5;
    fg_color = FG_A; bg_color = BG_A; border_color = BD_A;
    running = 1'b1;

    repeat (5) @(negedge clk);
    chk("reset_outputs", {4'h0, de, hsync, vsync, vblank_irq, red, green, blue},
        {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
    chk("reset_addr", 32'(vram_addr), 32'd0);
    #1 resetn = 1'b1;

    wait_k(4100);
    fg_color = FG_B; bg_color = BG_B; border_color = BD_B;
    wait_k(7900);
    fg_color = FG_A; bg_color = BG_A; border_color = BD_A;

    // Counter position 8917 is (17,9): inside the bitmap, mid-line.
    wait_k(8920);
    chk("irq_count_two_frames", 32'(irq_count), 32'd2);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_rgb_de", {7'h0, de, red, green, blue}, 32'h0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    wait_k(1000);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
